// File: rtl/audio_pkg.sv
// Shared audio constants, tone width and the note divider state encoding.
// The note_gen volume port is enabled by defining NOTE_GEN_VOLUME_EN.
package audio_pkg;

    localparam int unsigned CLK_HZ_DEF     = 100_000_000;
    localparam int unsigned SILENCE_HZ_DEF = 20000;
    localparam int unsigned TONE_W         = 32;
    localparam logic [15:0] AMP            = 16'h2000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/note_div.sv
// 32-bit restoring unsigned divider, one quotient bit per cycle.
// Start in IDLE, 32 iterations in RUN, one DONE cycle presenting the result.
module note_div
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TONE_W-1:0]   dividend,
    input  logic [TONE_W-1:0]   divisor,
    output logic                busy,
    output logic                done,
    output logic [TONE_W-1:0]   quotient
);

    div_state_t        state;
    logic [31:0]       rem;
    logic [31:0]       quo;
    logic [31:0]       dvs;
    logic [4:0]        it;
    logic [32:0]       rem_sh;
    logic [32:0]       sub;
    logic              ge;
    logic              unused_sub;

    // The remainder stays below the divisor, so sub[32] is always zero when used.
    always_comb begin
        rem_sh = {rem, quo[31]};
        ge     = rem_sh >= {1'b0, dvs};
        sub    = rem_sh - {1'b0, dvs};
    end

    assign unused_sub = sub[32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            it    <= '0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        rem   <= '0;
                        dvs   <= divisor;
                        it    <= '0;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    quo <= {quo[30:0], ge};
                    rem <= ge ? sub[31:0] : rem_sh[31:0];
                    it  <= it + 5'd1;
                    if (it == 5'd31)
                        state <= DIV_DONE;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy     = (state != DIV_IDLE);
    assign done     = (state == DIV_DONE);
    assign quotient = quo;

endmodule

// File: rtl/note_gen.sv
// Tone word to square wave and signed PCM sample via a half-period divide.
// Define NOTE_GEN_VOLUME_EN to add the 3-bit volume port.
module note_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned SILENCE_HZ = SILENCE_HZ_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [TONE_W-1:0]   tone,
`ifdef NOTE_GEN_VOLUME_EN
    input  logic [2:0]          volume,
`endif
    output logic                sq,
    output logic [15:0]         audio,
    output logic                busy
);

    logic [TONE_W-1:0] tone_q;
    logic [31:0]       half_q;
    logic [31:0]       cnt;
    logic [31:0]       quotient;
    logic              dbusy;
    logic              ddone;
    logic              silent;
    logic              accept;
    logic              start;
    logic [15:0]       amp;
    logic [15:0]       amp_neg;

    assign silent = (tone == '0) || (tone >= TONE_W'(SILENCE_HZ));
    assign accept = en && !dbusy && (tone != tone_q);
    assign start  = accept && !silent;

`ifdef NOTE_GEN_VOLUME_EN
    assign amp = (volume == 3'd0) ? 16'h0000 : (16'h7FFF >> (3'd7 - volume));
`else
    assign amp = AMP;
`endif
    assign amp_neg = ~amp + 16'd1;

    note_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (TONE_W'(CLK_HZ)),
        .divisor  ({tone[TONE_W-2:0], 1'b0}),
        .busy     (dbusy),
        .done     (ddone),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_q <= TONE_W'(SILENCE_HZ);
            half_q <= '0;
            cnt    <= '0;
            sq     <= 1'b0;
            audio  <= '0;
        end else begin
            audio <= (en && half_q != '0) ? (sq ? amp : amp_neg) : 16'h0000;
            if (accept)
                tone_q <= tone;
            // New half-period restarts the phase but keeps sq's level.
            if (ddone) begin
                half_q <= quotient;
                cnt    <= '0;
            end else if (accept && silent) begin
                half_q <= '0;
                cnt    <= '0;
                sq     <= 1'b0;
            end else if (en && half_q != '0) begin
                if (cnt == half_q - 32'd1) begin
                    cnt <= '0;
                    sq  <= ~sq;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end

    assign busy = dbusy;

endmodule

// File: tb/tb_note_gen.sv
// Directed bench for note_gen: divide latency, tone changes, mute, freeze, reset.
// Works with or without NOTE_GEN_VOLUME_EN.
module tb_note_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] tone;
    logic [2:0]  volume;
    logic        sq;
    logic [15:0] audio;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

`ifdef NOTE_GEN_VOLUME_EN
    localparam logic [15:0] AMP_P = 16'h7FFF;
    localparam logic [15:0] AMP_N = 16'h8001;
`else
    localparam logic [15:0] AMP_P = 16'h2000;
    localparam logic [15:0] AMP_N = 16'hE000;
`endif

    always #5 clk = ~clk;

    note_gen dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tone   (tone),
`ifdef NOTE_GEN_VOLUME_EN
        .volume (volume),
`endif
        .sq     (sq),
        .audio  (audio),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic count_busy(output int c);
        int t = 0;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        c = 0;
        while (busy && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_toggle(input int lim, output int c);
        logic s;
        s = sq;
        c = 0;
        while (sq == s && c < lim) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        tone = 32'd0;
        volume = 3'd7;
        repeat (3) @(negedge clk);
        chk("rst_sq", {31'd0, sq}, 32'd0);
        chk("rst_audio", {16'd0, audio}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_half", dut.half_q, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        en = 1'b1;
        tone = 32'd440;
        count_busy(n);
        chk("busy_440", n, 32'd33);
        chk("half_440", dut.half_q, 32'd113636);
        repeat (3) @(negedge clk);
        chk("aud_440_neg", {16'd0, audio}, {16'd0, AMP_N});

        tone = 32'd19999;
        count_busy(n);
        chk("busy_19999", n, 32'd33);
        chk("half_19999", dut.half_q, 32'd2500);
        wait_toggle(6000, n);
        chk("first_toggle", n, 32'd2500);
        wait_toggle(6000, n);
        chk("half_period", n, 32'd2500);

        repeat (1000) @(negedge clk);
        en = 1'b0;
        repeat (1000) @(negedge clk);
        chk("frz_cnt", dut.cnt, 32'd1000);
        chk("frz_audio", {16'd0, audio}, 32'd0);
        chk("frz_sq", {31'd0, sq}, 32'd0);
        en = 1'b1;
        wait_toggle(6000, n);
        chk("resume_toggle", n, 32'd1500);
        repeat (2) @(negedge clk);
        chk("aud_pos", {16'd0, audio}, {16'd0, AMP_P});

        tone = 32'd20000;
        @(posedge clk); #1;
        chk("sil_sq", {31'd0, sq}, 32'd0);
        chk("sil_aud_e0", {16'd0, audio}, {16'd0, AMP_P});
        @(posedge clk); #1;
        chk("sil_aud_e1", {16'd0, audio}, 32'd0);
        chk("sil_busy", {31'd0, busy}, 32'd0);
        chk("sil_half", dut.half_q, 32'd0);
        @(negedge clk);

        tone = 32'd19999;
        count_busy(n);
        wait_toggle(6000, n);
        repeat (2) @(negedge clk);
        tone = 32'd0;
        @(posedge clk); #1;
        chk("zero_sq", {31'd0, sq}, 32'd0);
        @(posedge clk); #1;
        chk("zero_aud", {16'd0, audio}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        tone = 32'd392;
        @(negedge clk);
        repeat (10) @(negedge clk);
        tone = 32'd524;
        count_busy(n);
        chk("half_392", dut.half_q, 32'd127551);
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("gap_1cyc", n, 32'd1);
        count_busy(n);
        chk("busy_524", n, 32'd33);
        chk("half_524", dut.half_q, 32'd95419);

        tone = 32'd494;
        @(negedge clk);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_sq", {31'd0, sq}, 32'd0);
        chk("mrst_audio", {16'd0, audio}, 32'd0);
        chk("mrst_half", dut.half_q, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (dut.half_q != 32'd101214 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat_494", n, 32'd34);

`ifdef NOTE_GEN_VOLUME_EN
        @(negedge clk);
        volume = 3'd0;
        repeat (2) @(negedge clk);
        chk("vol0", {16'd0, audio}, 32'd0);
        volume = 3'd1;
        repeat (2) @(negedge clk);
        chk("vol1", {16'd0, audio}, 32'h0000FE01);
        volume = 3'd4;
        repeat (2) @(negedge clk);
        chk("vol4", {16'd0, audio}, 32'h0000F001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
